// File: rtl/ddsm_mmd_ctrl.sv
// ddsm_mmd_ctrl: multi-modulus divider that adds one MASH code per period to the integer divide value
module ddsm_mmd_ctrl #(
    parameter int N_WIDTH = 8,
    parameter int MIN_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [N_WIDTH-1:0] n_int_i,
    input  logic [3:0]         y_i,
    output logic               y_ack_o,
    output logic               div_o,
    output logic [N_WIDTH-1:0] ratio_o,
    output logic               sat_o
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int W = N_WIDTH + 2;
    localparam logic signed [W-1:0] MAX_R = W'((2 ** N_WIDTH) - 1);
    state_t state, state_n;
    logic signed [W-1:0] raw;
    logic lo, hi, load, div_n, sat_n;
    logic [N_WIDTH-1:0] r, cnt, cnt_n, ratio_n;
    logic [N_WIDTH:0] half_n;
    assign raw = $signed({2'b00, n_int_i}) + $signed({{(W-4){y_i[3]}}, y_i});
    assign lo = raw < $signed(W'(MIN_DIV));
    assign hi = raw > MAX_R;
    assign r = lo ? N_WIDTH'(MIN_DIV) : hi ? '1 : raw[N_WIDTH-1:0];
    assign load = en_i && !rst && (state == IDLE || cnt == '0);
    assign y_ack_o = load;
    always_comb begin
        state_n = load ? RUN : (state == RUN && cnt == '0) ? IDLE : state;
        cnt_n = load ? r - N_WIDTH'(1) : (state == RUN && cnt != '0) ? cnt - N_WIDTH'(1) : cnt;
        ratio_n = load ? r : ratio_o;
        sat_n = sat_o | (load & (lo | hi));
        half_n = ({1'b0, ratio_n} + (N_WIDTH+1)'(1)) >> 1;
        // high while the remaining count is at least ceil(R/2)
        div_n = state_n == RUN && {1'b0, cnt_n} >= half_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            ratio_o <= '0;
            div_o <= 1'b0;
            sat_o <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            ratio_o <= ratio_n;
            div_o <= div_n;
            sat_o <= sat_n;
        end
    end
endmodule

// File: doc/ddsm_mmd_ctrl.md
Name: ddsm_mmd_ctrl

Overview:
- Consumer end of the MASH noise-cancellation output.
- Reads the 4-bit signed MASH code once per division period and adds it to the integer divide value.
- Runs a programmable down-counter that produces the divided clock `div_o`.
- Returns a per-period strobe `y_ack_o` that advances the DDSM/NCL chain, so fractional division happens entirely on the `clk` domain.

Parameters:
- N_WIDTH, 8, width of the integer divide value and of the ratio/counter.
- MIN_DIV, 4, smallest ratio allowed after clamping (≥2).

Ports:
- clk  input  1  clock, rising-edge only.
- rst  input  1  synchronous reset, active-high.
- en_i  input  1  run enable.
- n_int_i  input  N_WIDTH  unsigned integer divide value.
- y_i  input  4  two's-complement MASH code; NCL range −3..+4, full −8..+7 accepted.
- y_ack_o  output  1  Mealy strobe; high in the cycle whose closing edge samples `y_i`; the DDSM/NCL steps on that same edge.
- div_o  output  1  registered divided clock.
- ratio_o  output  N_WIDTH  ratio R of the current period; registered.
- sat_o  output  1  sticky flag: some sampled ratio needed clamping.

Behaviour:
- Clock and reset:
  - One clock domain: `clk`.
  - `rst` is synchronous, active-high, and overrides everything.
  - On reset: state=IDLE, cnt=0, ratio_o=0, div_o=0, sat_o=0. y_ack_o=0 while rst is high.
- Ratio arithmetic:
  - raw = zero-extend(n_int_i) + sign-extend(y_i), computed at N_WIDTH+2 bits signed.
  - R = MIN_DIV if raw < MIN_DIV; R = 2^N_WIDTH−1 if raw > 2^N_WIDTH−1; otherwise R = raw.
  - When a clamp is applied at a sampling edge, sat_o is set on that edge. It clears only on rst.
- Load strobe: load = en_i && (state==IDLE || cnt==0). y_ack_o = load.
- State IDLE:
  - div_o=0. cnt and ratio_o hold their values.
  - If load is high: ratio_o←R, cnt←R−1, go to RUN.
- State RUN:
  - cnt decrements by 1 on each edge. Period length is exactly R cycles.
  - At cnt==0 with en_i=1: reload on the same edge (ratio_o←R from the current y_i and n_int_i, cnt←R−1). No gap cycle.
  - At cnt==0 with en_i=0: go to IDLE, cnt stays 0, div_o←0.
  - en_i low while cnt>0 has no effect until the period ends. Periods are never truncated.
- div_o shaping:
  - Registered so that div_o is high in the cycles where cnt ≥ ceil(R/2).
  - This gives floor(R/2) high cycles at the start of each period, followed by ceil(R/2) low cycles.
  - Implement as a next-state compare so div_o is glitch-free.
- Input sampling:
  - n_int_i changes take effect only at the next load.
  - Exactly one y_i sample per period, so one DDSM step per div_o period.
- Reset mid-period: returns to IDLE on the next edge with no further strobes. A following en_i=1 restarts at a fresh load.
- Simultaneous rst and load: rst wins, no strobe is issued.

Test Plan:
- Reset and idle: assert rst 3 cycles, hold en_i=0 → div_o=0, y_ack_o=0, ratio_o=0, sat_o=0 throughout.
- Integer divide: n_int=10, y=0, en_i=1 → y_ack every 10 cycles, div_o high 5 cycles then low 5, ratio_o=10, sat_o=0.
- Fractional sequence: n_int=20, y codes +4,−3,0,+1 presented at each ack → period lengths 24,17,20,21; the first ack appears in the cycle en_i rises; div_o high 12,8,10,10.
- Clamp: n_int=5,y=−3 → R=4, sat_o=1 sticky; n_int=255,y=+4 → R=255 and the flag stays set.
  - Odd/minimum ratio check: R=4 gives div_o high 2 / low 2; n_int=7,y=0 gives high 3 / low 4.
- Enable drop and reset: deassert en_i at cnt=6 of R=10 → period completes, then IDLE with div_o=0 and no extra ack. Assert rst at cnt=3 → IDLE next edge, no ack, sat_o cleared.
